// File: rtl/mem_ctrl.sv
// Byte-serial arbiter sharing a single-port byte-wide RAM between instruction fetch and the
// memory stage; memory stage wins ties, each transaction ends with a one-cycle done pulse.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  input  logic        if_flush_in,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [31:0] mem_addr_in,
  input  logic [1:0]  mem_size_in,
  input  logic [31:0] mem_wdata_in,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  output logic [31:0] ram_a_out,
  output logic        ram_wr_out,
  output logic [7:0]  ram_dout_out,
  input  logic [7:0]  ram_din_in
);

  typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic        owner_mem_q, owner_mem_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [2:0]  mem_len;
  logic [1:0]  byte_idx;
  logic [31:0] asm_next;

  assign mem_len = (mem_size_in == 2'd0) ? 3'd1 : (mem_size_in == 2'd1) ? 3'd2 : 3'd4;

  // Byte read at cnt-1 arrives while cnt is shown, due to the one-cycle RAM latency.
  assign byte_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    asm_next = asm_q;
    asm_next[{byte_idx, 3'b000} +: 8] = ram_din_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      owner_mem_q <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      owner_mem_q <= owner_mem_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    owner_mem_d = owner_mem_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_in) begin
          base_d      = mem_addr_in;
          len_d       = mem_len;
          wdata_d     = mem_wdata_in;
          owner_mem_d = 1'b1;
          asm_d       = 32'd0;
          cnt_d       = 3'd0;
          state_d     = mem_we_in ? StMemWr : StMemRd;
        end else if (if_req_in && !if_flush_in) begin
          base_d      = if_addr_in;
          len_d       = 3'd4;
          owner_mem_d = 1'b0;
          asm_d       = 32'd0;
          cnt_d       = 3'd0;
          state_d     = StIfRd;
        end
      end
      StIfRd, StMemRd: begin
        if (state_q == StIfRd && if_flush_in) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) asm_d = asm_next;
          if (cnt_q == len_q) begin
            state_d = StDone;
            if (owner_mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_next;
            end else begin
              if_done_d = 1'b1;
              if_inst_d = asm_next;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StMemWr: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d    = StDone;
          mem_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    ram_a_out    = 32'd0;
    ram_wr_out   = 1'b0;
    ram_dout_out = 8'd0;
    unique case (state_q)
      StIfRd, StMemRd: begin
        if (cnt_q < len_q) ram_a_out = base_q + {29'd0, cnt_q};
      end
      StMemWr: begin
        ram_a_out    = base_q + {29'd0, cnt_q};
        ram_wr_out   = rdy_in;
        ram_dout_out = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: begin
        ram_a_out    = 32'd0;
        ram_wr_out   = 1'b0;
        ram_dout_out = 8'd0;
      end
    endcase
  end

  assign if_done_out   = if_done_q;
  assign if_inst_out   = if_inst_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: cycle-exact fetch, load, store, flush, wrap, stall and reset cases
// against a small byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;

  logic [7:0]  ram [4096];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .rdy_in        (rdy),
    .if_req_in     (if_req),
    .if_addr_in    (if_addr),
    .if_flush_in   (if_flush),
    .if_done_out   (if_done),
    .if_inst_out   (if_inst),
    .mem_req_in    (mem_req),
    .mem_we_in     (mem_we),
    .mem_addr_in   (mem_addr),
    .mem_size_in   (mem_size),
    .mem_wdata_in  (mem_wdata),
    .mem_done_out  (mem_done),
    .mem_rdata_out (mem_rdata),
    .ram_a_out     (ram_a),
    .ram_wr_out    (ram_wr),
    .ram_dout_out  (ram_dout),
    .ram_din_in    (ram_din)
  );

  // RAM shares the global ready, so its read byte holds while the controller is frozen.
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
      ram_din <= ram[ram_a[11:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) ram[i] = 8'd0;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h200] = 8'hF0; ram[12'h201] = 8'h77;
    rst_n = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_size = 2'd0; mem_wdata = 32'd0;
    #2;
    check_eq("rst if_done", {31'd0, if_done}, 32'd0);
    check_eq("rst mem_done", {31'd0, mem_done}, 32'd0);
    check_eq("rst if_inst", if_inst, 32'd0);
    check_eq("rst mem_rdata", mem_rdata, 32'd0);
    check_eq("rst ram_a", ram_a, 32'd0);
    check_eq("rst ram_wr", {31'd0, ram_wr}, 32'd0);
    check_eq("rst ram_dout", {24'd0, ram_dout}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Word fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("fetch ram_a", ram_a, 32'h100 + i);
      check_eq("fetch ram_wr", {31'd0, ram_wr}, 32'd0);
    end
    tick();
    check_eq("fetch c+5 ram_a", ram_a, 32'd0);
    check_eq("fetch c+5 if_done", {31'd0, if_done}, 32'd0);
    tick();
    check_eq("fetch c+6 if_done", {31'd0, if_done}, 32'd1);
    check_eq("fetch c+6 if_inst", if_inst, 32'h44332211);
    if_req = 1'b0;
    tick();
    check_eq("fetch c+7 if_done", {31'd0, if_done}, 32'd0);

    // Simultaneous requests: LB wins, then the fetch
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h200;
    tick();
    check_eq("arb lb ram_a", ram_a, 32'h200);
    tick();
    tick();
    check_eq("arb lb mem_done", {31'd0, mem_done}, 32'd1);
    check_eq("arb lb rdata", mem_rdata, 32'h000000F0);
    check_eq("arb if_done low", {31'd0, if_done}, 32'd0);
    mem_req = 1'b0;
    tick();
    check_eq("arb idle ram_a", ram_a, 32'd0);
    check_eq("arb idle mem_done", {31'd0, mem_done}, 32'd0);
    tick();
    check_eq("arb fetch ram_a", ram_a, 32'h100);
    repeat (4) tick();
    check_eq("arb fetch early done", {31'd0, if_done}, 32'd0);
    tick();
    check_eq("arb fetch if_done", {31'd0, if_done}, 32'd1);
    check_eq("arb fetch if_inst", if_inst, 32'h44332211);
    if_req = 1'b0;
    tick();

    // SW 0xDEADBEEF to 0x300
    w = 32'hDEADBEEF;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = w;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("sw ram_wr", {31'd0, ram_wr}, 32'd1);
      check_eq("sw ram_a", ram_a, 32'h300 + i);
      check_eq("sw ram_dout", {24'd0, ram_dout}, {24'd0, w[8*i +: 8]});
    end
    tick();
    check_eq("sw c+5 ram_wr", {31'd0, ram_wr}, 32'd0);
    check_eq("sw c+5 mem_done", {31'd0, mem_done}, 32'd1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check_eq("sw c+6 mem_done", {31'd0, mem_done}, 32'd0);
    check_eq("sw ram contents", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, w);

    // Flush in the third IF_RD cycle, pending LW then accepted
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) tick();
    check_eq("flush 3rd rd ram_a", ram_a, 32'h102);
    if_flush = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h300;
    tick();
    check_eq("flush idle ram_a", ram_a, 32'd0);
    check_eq("flush if_done", {31'd0, if_done}, 32'd0);
    if_flush = 1'b0; if_req = 1'b0;
    tick();
    check_eq("flush lw ram_a", ram_a, 32'h300);
    check_eq("flush if_done late", {31'd0, if_done}, 32'd0);
    repeat (4) tick();
    check_eq("flush lw early done", {31'd0, mem_done}, 32'd0);
    tick();
    check_eq("flush lw mem_done", {31'd0, mem_done}, 32'd1);
    check_eq("flush lw rdata", mem_rdata, 32'hDEADBEEF);
    mem_req = 1'b0;
    tick();

    // SH at 0xFFFFFFFF wraps to 0
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'hFFFFFFFF;
    mem_wdata = 32'h0000A55A;
    tick();
    check_eq("sh ram_a 0", ram_a, 32'hFFFFFFFF);
    check_eq("sh ram_dout 0", {24'd0, ram_dout}, 32'h5A);
    tick();
    check_eq("sh ram_a 1", ram_a, 32'h00000000);
    check_eq("sh ram_wr 1", {31'd0, ram_wr}, 32'd1);
    check_eq("sh ram_dout 1", {24'd0, ram_dout}, 32'hA5);
    tick();
    check_eq("sh mem_done", {31'd0, mem_done}, 32'd1);
    check_eq("sh ram_wr off", {31'd0, ram_wr}, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check_eq("sh ram bytes", {16'd0, ram[12'h000], ram[12'hFFF]}, 32'h0000A55A);

    // LW with rdy low for 3 cycles
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h300;
    repeat (2) tick();
    check_eq("stall ram_a pre", ram_a, 32'h301);
    rdy = 1'b0;
    tick();
    check_eq("stall ram_a hold", ram_a, 32'h301);
    check_eq("stall mem_done", {31'd0, mem_done}, 32'd0);
    repeat (2) tick();
    rdy = 1'b1;
    repeat (3) tick();
    check_eq("stall c+8 done", {31'd0, mem_done}, 32'd0);
    tick();
    check_eq("stall c+9 done", {31'd0, mem_done}, 32'd1);
    check_eq("stall rdata", mem_rdata, 32'hDEADBEEF);
    mem_req = 1'b0;
    tick();

    // Reset pulse mid-store
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h310; mem_wdata = 32'h12345678;
    tick();
    check_eq("rst sw ram_a 0", ram_a, 32'h310);
    tick();
    check_eq("rst sw ram_wr 1", {31'd0, ram_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst ram_wr", {31'd0, ram_wr}, 32'd0);
    check_eq("midrst ram_a", ram_a, 32'd0);
    check_eq("midrst ram_dout", {24'd0, ram_dout}, 32'd0);
    check_eq("midrst if_inst", if_inst, 32'd0);
    check_eq("midrst mem_rdata", mem_rdata, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("postrst mem_done", {31'd0, mem_done}, 32'd0);
      check_eq("postrst ram_wr", {31'd0, ram_wr}, 32'd0);
    end
    check_eq("partial store bytes", {16'd0, ram[12'h311], ram[12'h310]}, 32'h00000078);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
